// File: rtl/cse_bubble_pkg.sv
// Shared encodings, state enum and decode helper for the fetch/decode sequencer.
package cse_bubble_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic       legal;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic       shift;
    logic       branch;
    logic       jump;
    logic       zext;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    case (ins[31:26])
      OP_RTYPE: begin
        d.legal   = ins[5:0] inside {FN_SLL, FN_SRL, FN_ADD, FN_ADDU, FN_SUB,
                                     FN_SUBU, FN_AND, FN_OR, FN_SLT};
        d.shift   = ins[5:0] inside {FN_SLL, FN_SRL};
        d.wr_en   = d.legal;
        d.wr_addr = ins[15:11];
      end
      OP_ADDI: begin
        d.legal   = 1'b1;
        d.wr_en   = 1'b1;
        d.wr_addr = ins[20:16];
      end
      OP_ANDI, OP_ORI: begin
        d.legal   = 1'b1;
        d.wr_en   = 1'b1;
        d.wr_addr = ins[20:16];
        d.zext    = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.legal  = 1'b1;
        d.branch = 1'b1;
      end
      OP_J: begin
        d.legal  = 1'b1;
        d.branch = 1'b1;
        d.jump   = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 register file: two async read ports, one sync write port, r0 reads zero.
module regfile_32x32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] mem [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : mem[ra2];

endmodule

// File: rtl/fetch_decode_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer feeding an external ALU.
module fetch_decode_seq
  import cse_bubble_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 255,
  parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [31:0] alu_imm,
  output logic [5:0]  alu_op,
  output logic [5:0]  alu_funct,
  output logic        alu_branch,
  input  logic [31:0] alu_rd,
  input  logic        alu_branch_taken,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic        imem_error,
  output logic        illegal_instr,
  output logic [31:0] retired
);

  state_t      state, state_nxt;
  logic [31:0] pc, instr, rd_q;
  logic        taken_q;
  logic [7:0]  to_cnt;
  dec_t        dec;
  logic [31:0] rs_val, rt_val, pc4, imm_sext, imm_zext, br_tgt, j_tgt;
  logic        timeout;

  assign dec      = decode(instr);
  assign pc4      = pc + 32'd4;
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'b0, instr[15:0]};
  assign br_tgt   = pc4 + {imm_sext[29:0], 2'b00};
  assign j_tgt    = {pc4[31:28], instr[25:0], 2'b00};

  // Gated by rst_n so the request falls the instant reset asserts.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc;
  assign pc_out    = pc;
  assign timeout   = !imem_ack && (to_cnt == 8'(IMEM_TIMEOUT - 1));

  regfile_32x32 u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .we    (state == WRITEBACK && dec.wr_en),
    .wa    (dec.wr_addr),
    .wd    (rd_q),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:     if (imem_ack) state_nxt = DECODE;
                 else if (timeout) state_nxt = HALT;
      DECODE:    state_nxt = (instr == HALT_WORD) ? HALT : EXECUTE;
      EXECUTE:   state_nxt = WRITEBACK;
      WRITEBACK: state_nxt = FETCH;
      default:   state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      instr         <= '0;
      rd_q          <= '0;
      taken_q       <= 1'b0;
      to_cnt        <= '0;
      alu_rs        <= '0;
      alu_rt        <= '0;
      alu_imm       <= '0;
      alu_op        <= '0;
      alu_funct     <= '0;
      alu_branch    <= 1'b0;
      halted        <= 1'b0;
      imem_error    <= 1'b0;
      illegal_instr <= 1'b0;
      retired       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr  <= imem_rdata;
            to_cnt <= '0;
          end else if (timeout) begin
            halted     <= 1'b1;
            imem_error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (instr == HALT_WORD) begin
            halted <= 1'b1;
          end else begin
            alu_op     <= instr[31:26];
            alu_funct  <= instr[5:0];
            // Shifts move the shifted value into the rs slot, shamt into rt.
            alu_rs     <= dec.shift ? rt_val : rs_val;
            alu_rt     <= dec.shift ? {27'b0, instr[10:6]} : rt_val;
            alu_imm    <= dec.jump ? j_tgt : dec.branch ? br_tgt :
                          dec.zext ? imm_zext : imm_sext;
            alu_branch <= dec.branch;
            if (!dec.legal) illegal_instr <= 1'b1;
          end
        end
        EXECUTE: begin
          rd_q    <= alu_rd;
          taken_q <= alu_branch_taken;
        end
        WRITEBACK: begin
          pc      <= dec.jump ? alu_imm : (dec.branch && taken_q) ? rd_q : pc4;
          retired <= retired + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
